shl8_seq: RTL
=============

// Module: shl8_seq
// PURPOSE
// Multi-cycle left-shift sequencer that sits directly upstream of the 8-bit
// combinational left shifter and drives it. Accepts an 8-bit operand and a
// shift count wider than 3 bits (up to 2**CNT_W-1), splits it into chunks of
// at most 7, and feeds each chunk through the shifter. It accumulates the
// result and returns the final byte plus the last bit shifted out
// (8-bit ALU carry semantics) over valid/ready handshakes.
// PARAMETERS
// CNT_W  5  width of in_count; legal range 3..8
// PORTS
// clk        in   1      rising-edge clock
// rst_n      in   1      asynchronous active-low reset
// in_valid   in   1      request valid
// in_ready   out  1      request accepted when in_valid&in_ready
// in_a       in   8      operand
// in_count   in   CNT_W  shift count
// in_rot     in   1      rotate instead of shift (ROTATE_EN only)
// out_valid  out  1      result valid
// out_ready  in   1      result consumed when out_valid&out_ready
// out_res    out  8      result byte
// out_carry  out  1      last bit shifted out
// shl_a      out  8      to shifter operand (= internal acc register)
// shl_shift  out  3      to shifter amount (= min(rem,7); 0 outside SHIFT)
// shl_res    in   8      from shifter result
// shl_carry  in   1      from shifter carry
// BEHAVIOUR
// - Regs: state{IDLE,SHIFT,DONE}, acc[7:0], rem[CNT_W-1:0], carry.
//   out_res=acc, out_carry=carry.
// - Reset (async, rst_n=0): state=IDLE, acc=0, rem=0, carry=0.
//   Outputs are then out_valid=0, in_ready=1, out_res=0, out_carry=0,
//   shl_a=0, shl_shift=0.
// - in_ready=1 only in IDLE; out_valid=1 only in DONE. No overlap between requests.
// - IDLE, on accept: acc<=in_a, rem<=in_count, carry<=0.
//   Next state is DONE if in_count==0, else SHIFT.
// - SHIFT, each cycle: chunk=min(rem,7).
//   Normal step: acc<=shl_res, carry<=shl_carry, rem<=rem-chunk.
//   Go to DONE when rem-chunk==0; otherwise stay in SHIFT.
// - Zero shortcut: in SHIFT with acc==0 (and not rotating), take one cycle
//   with rem<=0, carry<=0, then go to DONE. Shifting zeros yields res 0, carry 0.
// - Latency from the accept edge to out_valid rising:
//   count==0: out_valid rises on the accept edge, so the result is visible
//   in the cycle immediately after acceptance.
//   count>0: ceil(count/7) further edges. The shortcut may reduce this.
// - DONE: out_res, out_carry and out_valid stay stable until out_ready=1.
//   On that handshake edge, go to IDLE. in_valid is ignored outside IDLE.
// - Counts >=9 give res 0. Carry is 1 only when count==8 and a[0]==1.
// - The shifter is purely combinational. shl_res/shl_carry are sampled in the
//   same cycle as shl_a/shl_shift.
// - Reset asserted mid-operation aborts immediately to the reset values.
//   No partial result is emitted.
// CONFIGURATION
// ROTATE_EN defined:
// - in_rot port exists. On accept with in_rot=1: rem<=in_count%8, rot flag set.
// - Rotating step: acc<=shl_res|(acc>>(8-chunk)), carry<=new acc[0].
//   The zero shortcut is disabled while rotating.
// - Effective rotate of 0 goes to DONE with carry=0.
// ROTATE_EN undefined:
// - in_rot port is absent. The block only shifts; no rotate logic is present.
// TESTING
// - in_a=0x81, count=1 -> 1 SHIFT cycle; out_res=0x02, out_carry=1.
// - in_a=0xFF, count=9 -> chunks 7,2; out_res=0x00, out_carry=0, out_valid after 2 edges.
// - in_a=0x01, count=8 -> chunks 7,1; out_res=0x00, out_carry=1.
// - in_a=0x5A, count=0 -> out_valid the cycle after accept; 0x5A, carry 0.
//   Repeat with in_a=0x00, count=20: shortcut gives 1 SHIFT cycle; 0x00, carry 0.
// - Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0.
//   Then rst_n=0 mid-SHIFT -> IDLE, all outputs at reset values.
// - ROTATE_EN: in_a=0x81, in_rot=1, count=1 -> 0x03, carry 1.
//   With count=9 -> same result, 1 SHIFT cycle.

Source files
------------

// File: rtl/shl8_seq.sv
// shl8_seq: multi-cycle left-shift sequencer driving an 8-bit combinational shifter; define ROTATE_EN for rotate support
module shl8_seq #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [CNT_W-1:0] in_count,
`ifdef ROTATE_EN
    input  logic             in_rot,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_res,
    output logic             out_carry,
    output logic [7:0]       shl_a,
    output logic [2:0]       shl_shift,
    input  logic [7:0]       shl_res,
    input  logic             shl_carry
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [7:0] acc, acc_nx;
    logic [CNT_W-1:0] rem, rem_nx;
    logic carry, carry_nx;
    logic [2:0] chunk;
`ifdef ROTATE_EN
    logic rot, rot_nx;
`endif
    assign chunk = (rem > CNT_W'(7)) ? 3'd7 : rem[2:0];
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign out_res = acc;
    assign out_carry = carry;
    assign shl_a = acc;
    assign shl_shift = (state == SHIFT) ? chunk : 3'd0;
    // Next state: load on accept, step one chunk per SHIFT cycle, hold result until consumed
    always_comb begin
        state_nx = state;
        acc_nx = acc;
        rem_nx = rem;
        carry_nx = carry;
`ifdef ROTATE_EN
        rot_nx = rot;
`endif
        if (state == IDLE) begin
            if (in_valid) begin
                acc_nx = in_a;
                rem_nx = in_count;
                carry_nx = 1'b0;
`ifdef ROTATE_EN
                rot_nx = in_rot;
                rem_nx = in_rot ? CNT_W'(in_count[2:0]) : in_count;
`endif
                state_nx = (rem_nx == '0) ? DONE : SHIFT;
            end
        end else if (state == SHIFT) begin
`ifdef ROTATE_EN
            if (acc == 8'd0 && !rot) begin
`else
            if (acc == 8'd0) begin
`endif
                rem_nx = '0;
                carry_nx = 1'b0;
                state_nx = DONE;
            end else begin
                acc_nx = shl_res;
                carry_nx = shl_carry;
`ifdef ROTATE_EN
                acc_nx = rot ? (shl_res | (acc >> (4'd8 - {1'b0, chunk}))) : shl_res;
                carry_nx = rot ? acc_nx[0] : shl_carry;
`endif
                rem_nx = rem - CNT_W'(chunk);
                state_nx = (rem_nx == '0) ? DONE : SHIFT;
            end
        end else if (out_ready) begin
            state_nx = IDLE;
        end
    end
    // State and datapath registers with asynchronous abort to reset values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc <= 8'd0;
            rem <= '0;
            carry <= 1'b0;
`ifdef ROTATE_EN
            rot <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            acc <= acc_nx;
            rem <= rem_nx;
            carry <= carry_nx;
`ifdef ROTATE_EN
            rot <= rot_nx;
`endif
        end
    end
endmodule
